y86_fetch_unit: RTL and testbench

Sequential Y86-64 fetch stage and the consumer of the next-PC value produced by the PC-update stage. Holds the architectural PC and fetches instruction bytes one per handshake from a byte-wide instruction memory. Assembles and decodes the instruction fields and presents one instruction to decode over a valid/ready handshake. Waits for the next PC load before fetching again.

---
 rtl/y86_pkg.sv | 41 ++++
 rtl/y86_inst_len.sv | 33 +++
 rtl/y86_fetch_unit.sv | 219 +++++++++++++++++++++
 tb/tb_y86_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, FSM states.
// Also holds the illegal-encoding check used when FETCH_ILLEGAL_CHECK_EN is defined.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_PRESENT,
    S_WAIT_PC,
    S_HALTED
  } state_t;

  function automatic logic illegal_inst(input logic [3:0] ic, input logic [3:0] fn);
    if (ic > I_POPQ) return 1'b1;
    case (ic)
      I_RRMOVQ, I_JXX: return fn > 4'd6;
      I_OPQ:           return fn > 4'd3;
      default:         return fn != 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_inst_len.sv
// Combinational icode decode: instruction length in bytes plus register/constant presence.
module y86_inst_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       has_regs,
  output logic       has_valc
);

  always_comb begin
    len      = 4'd1;
    has_regs = 1'b0;
    has_valc = 1'b0;
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        len      = 4'd2;
        has_regs = 1'b1;
      end
      I_JXX, I_CALL: begin
        len      = 4'd9;
        has_valc = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        len      = 4'd10;
        has_regs = 1'b1;
        has_valc = 1'b1;
      end
      default: len = 4'd1;
    endcase
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: byte-serial instruction fetch, field decode, valid/ready hand-off to decode.
// Optional FETCH_ILLEGAL_CHECK_EN flags bad icode/ifun encodings with STAT_INS and halts.
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [63:0] pc_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc_out,
  output logic [2:0]  stat,
  output logic        halted
);

  localparam logic [63:0] MEM_LIMIT = 64'(IMEM_SIZE);

  state_t      state, state_n;
  logic        req_q, discard_q;
  logic [63:0] pc_q, addr_q;
  logic [3:0]  cnt_q, cnt_nx;
  logic [3:0]  w_icode, w_ifun, w_ra, w_rb;
  logic [63:0] w_valc;
  logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
  logic [63:0] m_valc;
  logic [3:0]  sel_icode, len;
  logic        has_regs, has_valc;
  logic [63:0] cur_addr, next_addr;
  logic        cur_err, next_err, illegal0;
  logic        issue, capture, finish, adr_err, ins;
  logic [2:0]  vidx;

  assign cnt_nx    = cnt_q + 4'd1;
  assign cur_addr  = pc_q + {60'd0, cnt_q};
  assign next_addr = pc_q + {60'd0, cnt_nx};
  assign cur_err   = cur_addr >= MEM_LIMIT;
  assign next_err  = next_addr >= MEM_LIMIT;
  assign imem_addr = addr_q;
  // Byte 0 is decoded straight off the bus so length is known in the ack cycle
  assign sel_icode = (cnt_q == 4'd0) ? imem_rdata[7:4] : w_icode;
  assign vidx      = 3'(cnt_q - (has_regs ? 4'd2 : 4'd1));

`ifdef FETCH_ILLEGAL_CHECK_EN
  assign illegal0 = illegal_inst(imem_rdata[7:4], imem_rdata[3:0]);
`else
  assign illegal0 = 1'b0;
`endif

  y86_inst_len u_len (
    .icode    (sel_icode),
    .len      (len),
    .has_regs (has_regs),
    .has_valc (has_valc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    adr_err    = 1'b0;
    ins        = 1'b0;
    imem_req   = req_q;
    inst_valid = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        if (!pc_load) begin
          if (!req_q) begin
            if (cur_err) begin
              finish  = 1'b1;
              adr_err = 1'b1;
            end else begin
              issue = 1'b1;
            end
          end else if (imem_ack && !discard_q) begin
            capture = 1'b1;
            if (cnt_q == 4'd0 && illegal0) begin
              finish = 1'b1;
              ins    = 1'b1;
            end else if (cnt_nx == len) begin
              finish = 1'b1;
            end else if (next_err) begin
              finish  = 1'b1;
              adr_err = 1'b1;
            end
          end
        end
        if (finish) state_n = S_PRESENT;
      end
      S_PRESENT: begin
        inst_valid = 1'b1;
        if (inst_ready) state_n = (stat == STAT_AOK) ? S_WAIT_PC : S_HALTED;
      end
      S_WAIT_PC: begin
        if (pc_load) state_n = S_FETCH;
      end
      default: begin
        halted = 1'b1;
      end
    endcase
  end

  // Working fields with the arriving byte merged in; a new instruction starts from defaults
  always_comb begin
    m_icode = (cnt_q == 4'd0) ? I_HALT   : w_icode;
    m_ifun  = (cnt_q == 4'd0) ? 4'd0     : w_ifun;
    m_ra    = (cnt_q == 4'd0) ? REG_NONE : w_ra;
    m_rb    = (cnt_q == 4'd0) ? REG_NONE : w_rb;
    m_valc  = (cnt_q == 4'd0) ? 64'd0    : w_valc;
    if (capture) begin
      if (cnt_q == 4'd0) begin
        {m_icode, m_ifun} = imem_rdata;
      end else if (has_regs && cnt_q == 4'd1) begin
        {m_ra, m_rb} = imem_rdata;
      end else if (has_valc) begin
        m_valc[{vidx, 3'b000} +: 8] = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      addr_q    <= 64'd0;
      cnt_q     <= 4'd0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      w_icode   <= I_HALT;
      w_ifun    <= 4'd0;
      w_ra      <= REG_NONE;
      w_rb      <= REG_NONE;
      w_valc    <= 64'd0;
      icode     <= I_HALT;
      ifun      <= 4'd0;
      rA        <= REG_NONE;
      rB        <= REG_NONE;
      valC      <= 64'd0;
      valP      <= 64'd0;
      pc_out    <= 64'd0;
      stat      <= STAT_AOK;
    end else begin
      case (state)
        S_FETCH: begin
          if (pc_load) begin
            pc_q  <= pc_in;
            cnt_q <= 4'd0;
            // An outstanding read must still finish; remember to drop its byte
            if (req_q && !imem_ack) begin
              discard_q <= 1'b1;
            end else begin
              req_q     <= 1'b0;
              discard_q <= 1'b0;
            end
          end else if (!req_q) begin
            if (issue) begin
              req_q  <= 1'b1;
              addr_q <= cur_addr;
            end
          end else if (imem_ack) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              req_q     <= 1'b0;
            end else begin
              w_icode <= m_icode;
              w_ifun  <= m_ifun;
              w_ra    <= m_ra;
              w_rb    <= m_rb;
              w_valc  <= m_valc;
              cnt_q   <= cnt_nx;
              if (finish) req_q  <= 1'b0;
              else        addr_q <= next_addr;
            end
          end
          if (finish) begin
            icode  <= m_icode;
            ifun   <= m_ifun;
            rA     <= m_ra;
            rB     <= m_rb;
            valC   <= m_valc;
            valP   <= capture ? next_addr : cur_addr;
            pc_out <= pc_q;
            if (adr_err)               stat <= STAT_ADR;
            else if (ins)              stat <= STAT_INS;
            else if (m_icode == I_HALT) stat <= STAT_HLT;
            else                       stat <= STAT_AOK;
          end
        end
        S_WAIT_PC: begin
          if (pc_load) begin
            pc_q  <= pc_in;
            cnt_q <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed self-checking bench for y86_fetch_unit with a byte-wide memory responder.
module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_load = 1'b0;
  logic [63:0] pc_in = 64'd0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [7:0]  imem_rdata = 8'h00;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc_out;
  logic [2:0]  stat;
  logic        halted;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:1023];
  logic [63:0] addr_log [$];
  int          ack_delay = 0;
  int          wait_cnt = 0;

  y86_fetch_unit #(.RESET_PC(64'h0), .IMEM_SIZE(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .icode      (icode),
    .ifun       (ifun),
    .rA         (rA),
    .rB         (rB),
    .valC       (valC),
    .valP       (valP),
    .pc_out     (pc_out),
    .stat       (stat),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Memory model: acks after ack_delay idle cycles, logging each served address
  always @(negedge clk) begin
    imem_ack = 1'b0;
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = (imem_addr < 64'd1024) ? mem[imem_addr[9:0]] : 8'h00;
        addr_log.push_back(imem_addr);
        wait_cnt   = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset(input bit load, input logic [63:0] pc);
    pc_load    = 1'b0;
    inst_ready = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    addr_log.delete();
    rst_n   = 1'b1;
    pc_load = load;
    pc_in   = pc;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic accept();
    inst_ready = 1'b1;
    @(posedge clk);
    #1;
    inst_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    clear_mem();
    mem[0] = 8'h10;
    ack_delay = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({imem_req, inst_valid, halted} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: req/valid/halted=%b want 000", {imem_req, inst_valid, halted});
    end
    n_checks++;
    if ({icode, ifun, rA, rB, stat} !== {4'h0, 4'h0, 4'hF, 4'hF, 3'd1}) begin
      n_fail++; $display("FAIL reset_fields: icode=%h ifun=%h rA=%h rB=%h stat=%0d want 0 0 f f 1", icode, ifun, rA, rB, stat);
    end
    n_checks++;
    if ({valC, valP, pc_out} !== 192'd0) begin
      n_fail++; $display("FAIL reset_vals: valC=%h valP=%h pc_out=%h want 0", valC, valP, pc_out);
    end
    addr_log.delete();
    rst_n = 1'b1;
    wait_valid(50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL nop_timeout: inst_valid=0 want 1");
    end
    n_checks++;
    if (addr_log.size() != 1 || addr_log[0] !== 64'd0) begin
      n_fail++; $display("FAIL nop_reqs: count=%0d want 1 at addr 0", addr_log.size());
    end
    n_checks++;
    if ({icode, ifun, rA, rB, stat} !== {4'h1, 4'h0, 4'hF, 4'hF, 3'd1} || valP !== 64'd1) begin
      n_fail++; $display("FAIL nop_fields: icode=%h rA=%h rB=%h stat=%0d valP=%0d want 1 f f 1 1", icode, rA, rB, stat, valP);
    end
    accept();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({imem_req, inst_valid, halted} !== 3'b000 || addr_log.size() != 1) begin
      n_fail++; $display("FAIL nop_wait: req/valid/halted=%b reqs=%0d want 000 and 1", {imem_req, inst_valid, halted}, addr_log.size());
    end
  endtask

  task automatic test_irmovq();
    bit ok;
    logic [7:0] prog [10] = '{8'h30, 8'hF3, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
    bit addr_ok;
    clear_mem();
    for (int i = 0; i < 10; i++) mem[4 + i] = prog[i];
    ack_delay = 2;
    do_reset(1'b1, 64'd4);
    wait_valid(200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL irmovq_timeout: inst_valid=0 want 1");
    end
    addr_ok = (addr_log.size() == 10);
    for (int i = 0; i < addr_log.size() && i < 10; i++)
      if (addr_log[i] !== 64'(4 + i)) addr_ok = 1'b0;
    n_checks++;
    if (!addr_ok) begin
      n_fail++; $display("FAIL irmovq_reqs: count=%0d want 10 at 4..13", addr_log.size());
    end
    n_checks++;
    if ({icode, ifun, rA, rB} !== {4'h3, 4'h0, 4'hF, 4'h3} || stat !== 3'd1) begin
      n_fail++; $display("FAIL irmovq_fields: icode=%h ifun=%h rA=%h rB=%h stat=%0d want 3 0 f 3 1", icode, ifun, rA, rB, stat);
    end
    n_checks++;
    if (valC !== 64'hDEADBEEF || valP !== 64'd14 || pc_out !== 64'd4) begin
      n_fail++; $display("FAIL irmovq_vals: valC=%h valP=%0d pc_out=%0d want deadbeef 14 4", valC, valP, pc_out);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1 || valC !== 64'hDEADBEEF || rB !== 4'h3) begin
      n_fail++; $display("FAIL irmovq_hold: valid=%b valC=%h rB=%h want 1 deadbeef 3", inst_valid, valC, rB);
    end
    accept();
  endtask

  task automatic test_jxx();
    bit ok;
    clear_mem();
    mem[0] = 8'h73;
    mem[1] = 8'h20;
    mem[32] = 8'h10;
    ack_delay = 0;
    do_reset(1'b0, 64'd0);
    wait_valid(100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL jxx_timeout: inst_valid=0 want 1");
    end
    n_checks++;
    if ({icode, ifun, rA, rB} !== {4'h7, 4'h3, 4'hF, 4'hF} || valC !== 64'd32 || valP !== 64'd9) begin
      n_fail++; $display("FAIL jxx_fields: icode=%h ifun=%h rA=%h rB=%h valC=%0d valP=%0d want 7 3 f f 32 9", icode, ifun, rA, rB, valC, valP);
    end
    accept();
    repeat (2) @(negedge clk);
    addr_log.delete();
    pc_load = 1'b1;
    pc_in   = 64'd32;
    @(negedge clk);
    pc_load = 1'b0;
    wait_valid(100, ok);
    n_checks++;
    if (!ok || addr_log.size() != 1 || addr_log[0] !== 64'd32) begin
      n_fail++; $display("FAIL jxx_next: valid=%b reqs=%0d want 1 req at 32", ok, addr_log.size());
    end
    n_checks++;
    if (pc_out !== 64'd32 || valP !== 64'd33 || icode !== 4'h1) begin
      n_fail++; $display("FAIL jxx_next_fields: pc_out=%0d valP=%0d icode=%h want 32 33 1", pc_out, valP, icode);
    end
    accept();
  endtask

  task automatic test_halt();
    bit ok;
    clear_mem();
    mem[5] = 8'h10;
    ack_delay = 1;
    do_reset(1'b0, 64'd0);
    wait_valid(100, ok);
    n_checks++;
    if (!ok || stat !== 3'd2 || icode !== 4'h0) begin
      n_fail++; $display("FAIL halt_stat: valid=%b stat=%0d icode=%h want 1 2 0", ok, stat, icode);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1 || halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_hold: valid=%b halted=%b want 1 0", inst_valid, halted);
    end
    accept();
    n_checks++;
    if (halted !== 1'b1 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_enter: halted=%b valid=%b want 1 0", halted, inst_valid);
    end
    addr_log.delete();
    pc_load = 1'b1;
    pc_in   = 64'd5;
    @(negedge clk);
    pc_load = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || addr_log.size() != 0) begin
      n_fail++; $display("FAIL halt_ignore_load: halted=%b req=%b reqs=%0d want 1 0 0", halted, imem_req, addr_log.size());
    end
  endtask

  task automatic test_adr();
    bit ok;
    clear_mem();
    mem[1023] = 8'h30;
    ack_delay = 0;
    do_reset(1'b1, 64'd1023);
    wait_valid(100, ok);
    n_checks++;
    if (!ok || addr_log.size() != 1 || addr_log[0] !== 64'd1023) begin
      n_fail++; $display("FAIL adr_reqs: valid=%b reqs=%0d want 1 req at 1023", ok, addr_log.size());
    end
    n_checks++;
    if (stat !== 3'd3 || icode !== 4'h3 || pc_out !== 64'd1023) begin
      n_fail++; $display("FAIL adr_stat: stat=%0d icode=%h pc_out=%0d want 3 3 1023", stat, icode, pc_out);
    end
    accept();
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL adr_halt: halted=%b want 1", halted);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    bit seen;
    clear_mem();
    mem[0] = 8'h30;
    mem[1] = 8'hF3;
    mem[100] = 8'h10;
    ack_delay = 4;
    do_reset(1'b0, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      if (addr_log.size() >= 1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL redir_first_ack: acks=%0d want 1", addr_log.size());
    end
    @(negedge clk);
    pc_load = 1'b1;
    pc_in   = 64'd100;
    @(negedge clk);
    pc_load = 1'b0;
    wait_valid(200, ok);
    n_checks++;
    if (!ok || addr_log.size() != 3 || addr_log[1] !== 64'd1 || addr_log[2] !== 64'd100) begin
      n_fail++; $display("FAIL redir_reqs: valid=%b reqs=%0d want 3 (0,1,100)", ok, addr_log.size());
    end
    n_checks++;
    if (icode !== 4'h1 || pc_out !== 64'd100 || valP !== 64'd101 || stat !== 3'd1 || rB !== 4'hF) begin
      n_fail++; $display("FAIL redir_fields: icode=%h pc_out=%0d valP=%0d stat=%0d rB=%h want 1 100 101 1 f", icode, pc_out, valP, stat, rB);
    end
    accept();
  endtask

  task automatic test_illegal();
    bit ok;
    clear_mem();
    mem[0] = 8'hC0;
    ack_delay = 0;
    do_reset(1'b0, 64'd0);
    wait_valid(100, ok);
    n_checks++;
    if (!ok || icode !== 4'hC) begin
      n_fail++; $display("FAIL illegal_present: valid=%b icode=%h want 1 c", ok, icode);
    end
`ifdef FETCH_ILLEGAL_CHECK_EN
    n_checks++;
    if (stat !== 3'd4) begin
      n_fail++; $display("FAIL illegal_stat: stat=%0d want 4", stat);
    end
    accept();
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL illegal_halt: halted=%b want 1", halted);
    end
`else
    n_checks++;
    if (stat !== 3'd1 || valP !== 64'd1) begin
      n_fail++; $display("FAIL unknown_stat: stat=%0d valP=%0d want 1 1", stat, valP);
    end
    accept();
    n_checks++;
    if (halted !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL unknown_wait: halted=%b req=%b want 0 0", halted, imem_req);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_jxx();
    test_halt();
    test_adr();
    test_redirect();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
